load_align_unit: RTL

Data-memory load stage placed directly after the load address calculator.
- Accepts a computed 32-bit byte address, RISC-V load funct3 and destination register.
- Issues a word-aligned read to a synchronous data memory and waits a fixed latency.
- Extracts the addressed byte/halfword/word, sign- or zero-extends it, and returns it with a valid/ready handshake.
- Flags misaligned or illegal loads without touching memory.

---
 rtl/load_align_unit_if.sv | 29 ++
 rtl/load_align_unit.sv | 127 ++++++++++++
 2 files changed

// File: rtl/load_align_unit_if.sv
// Load-unit bus bundle: request in, word read to data memory, aligned response out.
// slave is the load unit's view; master is the requester/memory/consumer side.
interface load_align_unit_if #(
    parameter int ADDR_W = 14
);
    logic              req_valid;
    logic              req_ready;
    logic [31:0]       req_addr;
    logic [2:0]        req_funct3;
    logic [4:0]        req_rd;
    logic              dmem_en;
    logic [ADDR_W-1:0] dmem_addr;
    logic [31:0]       dmem_dout;
    logic              resp_valid;
    logic              resp_ready;
    logic [31:0]       resp_data;
    logic [4:0]        resp_rd;
    logic              resp_err;

    modport slave (
        input  req_valid, req_addr, req_funct3, req_rd, dmem_dout, resp_ready,
        output req_ready, dmem_en, dmem_addr, resp_valid, resp_data, resp_rd, resp_err
    );

    modport master (
        output req_valid, req_addr, req_funct3, req_rd, dmem_dout, resp_ready,
        input  req_ready, dmem_en, dmem_addr, resp_valid, resp_data, resp_rd, resp_err
    );
endinterface

// File: rtl/load_align_unit.sv
// RISC-V load stage: one word read per legal load, result ready MEM_LATENCY+1 cycles after accept.
// Single outstanding load; response held until resp_ready, illegal loads answer in 1 cycle with no memory access.
module load_align_unit #(
    parameter int ADDR_W      = 14,
    parameter int MEM_LATENCY = 1
) (
    input  logic               clk,
    input  logic               rst,
    load_align_unit_if.slave   bus
);
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    localparam logic [1:0] CNT_INIT = 2'(MEM_LATENCY - 1);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [1:0]  r_cnt;
    logic [1:0]  r_off;
    logic [2:0]  r_funct3;
    logic [4:0]  r_rd;
    logic        r_resp_valid;
    logic [31:0] r_resp_data;
    logic [4:0]  r_resp_rd;
    logic        r_resp_err;

    logic        w_accept;
    logic        w_legal;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_ext;
    logic        w_unused_addr;

    assign w_accept = bus.req_valid && (r_state == S_IDLE);

    always_comb begin
        w_legal = 1'b0;
        case (bus.req_funct3)
            3'b000, 3'b100: w_legal = 1'b1;
            3'b001, 3'b101: w_legal = ~bus.req_addr[0];
            3'b010:         w_legal = (bus.req_addr[1:0] == 2'b00);
            default:        w_legal = 1'b0;
        endcase
    end

    // Address bits above the memory window alias silently.
    assign w_unused_addr = ^bus.req_addr[31:ADDR_W+2];

    assign bus.req_ready = (r_state == S_IDLE);
    assign bus.dmem_en   = w_accept && w_legal;
    assign bus.dmem_addr = bus.dmem_en ? bus.req_addr[ADDR_W+1:2] : '0;

    assign w_byte = bus.dmem_dout[{r_off, 3'b000} +: 8];
    assign w_half = r_off[1] ? bus.dmem_dout[31:16] : bus.dmem_dout[15:0];

    always_comb begin
        w_ext = bus.dmem_dout;
        case (r_funct3)
            3'b000:  w_ext = {{24{w_byte[7]}}, w_byte};
            3'b100:  w_ext = {24'h0, w_byte};
            3'b001:  w_ext = {{16{w_half[15]}}, w_half};
            3'b101:  w_ext = {16'h0, w_half};
            default: w_ext = bus.dmem_dout;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_state_nxt = w_legal ? S_WAIT : S_RESP;
            S_WAIT:  if (r_cnt == 2'd0) w_state_nxt = S_RESP;
            S_RESP:  if (bus.resp_ready) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_cnt        <= 2'd0;
            r_off        <= 2'd0;
            r_funct3     <= 3'd0;
            r_rd         <= 5'd0;
            r_resp_valid <= 1'b0;
            r_resp_data  <= 32'd0;
            r_resp_rd    <= 5'd0;
            r_resp_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_rd <= bus.req_rd;
                        if (w_legal) begin
                            r_off    <= bus.req_addr[1:0];
                            r_funct3 <= bus.req_funct3;
                            r_cnt    <= CNT_INIT;
                        end else begin
                            r_resp_valid <= 1'b1;
                            r_resp_err   <= 1'b1;
                            r_resp_data  <= 32'd0;
                            r_resp_rd    <= bus.req_rd;
                        end
                    end
                end
                S_WAIT: begin
                    if (r_cnt == 2'd0) begin
                        r_resp_valid <= 1'b1;
                        r_resp_err   <= 1'b0;
                        r_resp_data  <= w_ext;
                        r_resp_rd    <= r_rd;
                    end else begin
                        r_cnt <= r_cnt - 2'd1;
                    end
                end
                S_RESP: begin
                    if (bus.resp_ready) r_resp_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign bus.resp_valid = r_resp_valid;
    assign bus.resp_data  = r_resp_data;
    assign bus.resp_rd    = r_resp_rd;
    assign bus.resp_err   = r_resp_err;
endmodule
